// File: rtl/adc0808_responder.sv
// adc0808_responder: behavioural stand-in for an 8-channel SAR converter.
// It latches a channel address on ALE, runs an 8-bit successive-approximation
// conversion between the START edges, raises EOC when done, and drives the
// result onto the data bus while OE is high.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | EOC high, result stable, waiting for a START rise
// CLEAR   | SAR cleared, EOC low, waiting for the START fall
// CONVERT | busy high, one SAR bit trial every STEP_CYCLES clocks
module adc0808_responder #(
    parameter int STEP_CYCLES = 4,
    parameter int NCH         = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2:0]       add,
    input  logic             ALE,
    input  logic             START,
    input  logic             OE,
    input  logic [8*NCH-1:0] ch_data,
    output logic [7:0]       data,
    output logic             data_en,
    output logic             EOC,
    output logic             busy
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] STEP_LOAD = CW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        CONVERT = 2'd2
    } state_t;

    state_t        state;
    logic          ale_q;
    logic          start_q;
    logic          ale_rise;
    logic          start_rise;
    logic          start_fall;
    logic [2:0]    addr_q;
    logic [7:0]    hold;
    logic [7:0]    sar;
    logic [7:0]    result;
    logic [7:0]    trial;
    logic [7:0]    sar_kept;
    logic [7:0]    ch_sel;
    logic [2:0]    bit_idx;
    logic [CW-1:0] step_cnt;

    assign ale_rise   = ALE & ~ale_q;
    assign start_rise = START & ~start_q;
    assign start_fall = ~START & start_q;

    // Bit trial for the current position; the bit survives if the trial does not overshoot.
    assign trial    = sar | (8'h01 << bit_idx);
    assign sar_kept = (trial <= hold) ? trial : sar;

    assign data    = OE ? result : 8'h00;
    assign data_en = OE;

    // Channel mux; addresses without a physical channel read as zero.
    always_comb begin
        ch_sel = 8'h00;
        for (int i = 0; i < NCH; i++) begin
            if (addr_q == 3'(i)) begin
                ch_sel = ch_data[8*i +: 8];
            end
        end
    end

    // Edge-detect history for ALE and START.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ale_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            ale_q   <= ALE;
            start_q <= START;
        end
    end

    // Address latch; legal in any state, only the next conversion sees it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q <= 3'd0;
        end else if (ale_rise) begin
            addr_q <= add;
        end
    end

    // Conversion sequencer: bit timing is a reloading down-counter per SAR bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            sar      <= 8'h00;
            hold     <= 8'h00;
            result   <= 8'h00;
            bit_idx  <= 3'd0;
            step_cnt <= '0;
            EOC      <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state <= CLEAR;
                        sar   <= 8'h00;
                        EOC   <= 1'b0;
                    end
                end
                CLEAR: begin
                    sar  <= 8'h00;
                    EOC  <= 1'b0;
                    busy <= 1'b0;
                    if (start_fall) begin
                        state    <= CONVERT;
                        busy     <= 1'b1;
                        hold     <= ch_sel;
                        bit_idx  <= 3'd7;
                        step_cnt <= STEP_LOAD;
                    end
                end
                CONVERT: begin
                    if (start_rise) begin
                        // Restart request: drop the partial result, keep the old one visible.
                        state <= CLEAR;
                        sar   <= 8'h00;
                        busy  <= 1'b0;
                    end else if (step_cnt != '0) begin
                        step_cnt <= step_cnt - 1'b1;
                    end else begin
                        sar <= sar_kept;
                        if (bit_idx == 3'd0) begin
                            result <= sar_kept;
                            EOC    <= 1'b1;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            bit_idx  <= bit_idx - 3'd1;
                            step_cnt <= STEP_LOAD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    EOC   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc0808_responder.sv
// tb_adc0808_responder: scoreboard bench. The driver pushes the expected result
// and EOC cycle for every conversion; a monitor pops them when EOC rises.
module tb_adc0808_responder;

    localparam int STEP_CYCLES = 4;
    localparam int NCH         = 8;
    localparam int CONV        = 8 * STEP_CYCLES;

    typedef struct {
        logic [7:0] val;
        int         eoc_cyc;
    } exp_t;

    logic             CLK = 1'b0;
    logic             RST;
    logic [2:0]       add;
    logic             ALE;
    logic             START;
    logic             OE;
    logic [8*NCH-1:0] ch_data;
    logic [7:0]       data;
    logic             data_en;
    logic             EOC;
    logic             busy;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    exp_t       sbq[$];
    logic [7:0] chv[NCH];
    logic [7:0] last_result = 8'h00;
    logic       eoc_prev    = 1'b1;
    bit         rand_oe     = 1'b0;

    adc0808_responder #(.STEP_CYCLES(STEP_CYCLES), .NCH(NCH)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .add     (add),
        .ALE     (ALE),
        .START   (START),
        .OE      (OE),
        .ch_data (ch_data),
        .data    (data),
        .data_en (data_en),
        .EOC     (EOC),
        .busy    (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic put_ch(input int i, input logic [7:0] v);
        chv[i] = v;
        ch_data[8*i +: 8] = v;
    endtask

    // Monitor: every falling edge, compare bus outputs against the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                last_result = 8'h00;
            end else begin
                if (sbq.size() != 0)
                    chk("busy", busy, (cyc >= sbq[0].eoc_cyc - CONV && cyc < sbq[0].eoc_cyc) ? 1 : 0);
                else
                    chk("busy_idle", busy, 0);
                if (EOC && !eoc_prev) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_eoc: got EOC rise with empty scoreboard (cycle %0d)", cyc);
                    end else begin
                        e = sbq.pop_front();
                        chk("eoc_cycle", cyc, e.eoc_cyc);
                        chk("result", data, OE ? e.val : 8'h00);
                        last_result = e.val;
                    end
                end
                chk("data_vs_oe", data, OE ? last_result : 8'h00);
                chk("data_en", data_en, OE);
            end
            eoc_prev = EOC;
        end
    end

    // Starts a conversion on channel a and leaves the DUT in CONVERT.
    task automatic start_conv(input logic [2:0] a, input bit tie, input int gap);
        add = a;
        if (!tie) begin
            ALE = 1'b1;
            tick();
            ALE = 1'b0;
            add = 3'($urandom);
        end
        ALE   = tie;
        START = 1'b1;
        tick();
        ALE = 1'b0;
        add = 3'($urandom);
        chk("eoc_low_after_start", EOC, 0);
        repeat (gap) tick();
        START = 1'b0;
        sbq.push_back('{val: chv[a], eoc_cyc: cyc + 1 + CONV});
        tick();
    endtask

    task automatic wait_done();
        for (int i = 0; i < CONV + 8; i++) begin
            if (sbq.size() == 0) break;
            if (rand_oe) OE = 1'($urandom);
            tick();
        end
        chk("eoc_timeout_pending", sbq.size(), 0);
        sbq.delete();
        OE = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST   = 1'b1;
        add   = 3'd0;
        ALE   = 1'b0;
        START = 1'b0;
        OE    = 1'b1;
        ch_data = '0;
        for (int i = 0; i < NCH; i++) put_ch(i, 8'($urandom));
        repeat (3) tick();
        RST = 1'b0;
        tick();

        // Reset state
        chk("reset_eoc", EOC, 1);
        chk("reset_busy", busy, 0);
        chk("reset_data", data, 8'h00);

        // Basic conversion on channel 2
        put_ch(2, 8'hA5);
        start_conv(3'd2, 1'b0, 0);
        chk("busy_in_convert", busy, 1);
        wait_done();
        chk("ch2_result", data, 8'hA5);

        // ALE tied to START, SAR endpoints
        put_ch(3, 8'h00);
        start_conv(3'd3, 1'b1, 0);
        wait_done();
        chk("ch3_zero", data, 8'h00);
        put_ch(3, 8'hFF);
        start_conv(3'd3, 1'b1, 1);
        wait_done();
        chk("ch3_full", data, 8'hFF);

        // Channel change during conversion is ignored
        put_ch(2, 8'hA5);
        start_conv(3'd2, 1'b0, 2);
        repeat (5) tick();
        put_ch(2, 8'h11);
        wait_done();
        chk("hold_ignores_change", data, 8'hA5);

        // Restart 10 cycles into a conversion
        put_ch(1, 8'h3C);
        start_conv(3'd1, 1'b0, 0);
        repeat (10) tick();
        chk("abort_busy_before", busy, 1);
        START = 1'b1;
        tick();
        void'(sbq.pop_back());
        chk("abort_eoc_low", EOC, 0);
        chk("abort_busy_low", busy, 0);
        chk("abort_old_result", data, 8'hA5);
        START = 1'b0;
        sbq.push_back('{val: chv[1], eoc_cyc: cyc + 1 + CONV});
        tick();
        put_ch(1, 8'h77);
        wait_done();
        chk("abort_new_result", data, 8'h3C);

        // Reset mid-conversion
        put_ch(4, 8'h5A);
        start_conv(3'd4, 1'b0, 0);
        repeat (5) tick();
        RST = 1'b1;
        #1;
        chk("rst_mid_eoc", EOC, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_data", data, 8'h00);
        sbq.delete();
        tick();
        tick();
        RST = 1'b0;
        tick();

        // Randomized conversions
        rand_oe = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic [2:0] a;
            int         sel;
            a   = 3'($urandom_range(0, NCH - 1));
            sel = $urandom_range(0, 5);
            put_ch(a, (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom));
            start_conv(a, 1'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < NCH; i++) put_ch(i, 8'($urandom));
            end
            wait_done();
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
